carregador_programa: RTL and testbench
======================================

# carregador_programa

Boot-time program loader sitting directly upstream of the instruction memory and the nRisc core. It accepts a framed byte stream (length, instruction bytes, checksum) over a valid/ready handshake and writes each instruction byte into instruction memory through a write port. It holds the processor in reset until a frame with a correct checksum has been fully written, then releases it. A checksum mismatch raises a sticky error and keeps the core in reset.

## Interface
Parameters:
- ENDERECO_BASE, 8'h00, instruction-memory address that receives the first instruction byte.
- CICLOS_LIBERA, 2, extra cycles that ResetProcessador stays high after a good checksum; legal range 0..15.

Ports:
- Clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- DadoEntrada  input  8  incoming stream byte.
- ValidoEntrada  input  1  DadoEntrada is valid this cycle.
- ProntoEntrada  output  1  loader can accept a byte this cycle.
- Recarrega  input  1  single-cycle request to start a new load; honoured only in LIBERA or ERRO.
- EscInstr  output  1  instruction-memory write enable, one cycle per instruction byte.
- EnderecoInstr  output  8  instruction-memory write address.
- DadoInstr  output  8  instruction-memory write data.
- ResetProcessador  output  1  active-high reset to the nRisc core.
- Carregado  output  1  high while in LIBERA with the release countdown finished (core running).
- Erro  output  1  sticky checksum-mismatch flag.

## Operation
- A byte is accepted on a rising edge where ValidoEntrada && ProntoEntrada. ProntoEntrada is high in ESPERA_TAM, CARREGA and CHECA, and low in ATRASO, LIBERA and ERRO. DadoEntrada is ignored when not accepted.
- State ESPERA_TAM:
  - The accepted byte is stored as N (length) and the checksum accumulator is cleared to 0.
  - If N==0, go to CHECA. Otherwise go to CARREGA with contador=0.
- State CARREGA: each accepted byte b:
  - Write b at address ENDERECO_BASE+contador (mod 256).
  - soma = (soma + b) mod 256.
  - contador increments.
  - After the N-th byte, go to CHECA.
- State CHECA: the accepted byte is compared with soma.
  - Equal: go to ATRASO with a cycle counter loaded with CICLOS_LIBERA.
  - Not equal: go to ERRO and set Erro.
- State ATRASO: the counter decrements each cycle. Leave ATRASO for LIBERA on the cycle the counter is 0; with CICLOS_LIBERA=0, ATRASO lasts one cycle.
- State LIBERA: ResetProcessador is low and Carregado is high. Recarrega moves the block to ESPERA_TAM and re-asserts ResetProcessador.
- State ERRO: ResetProcessador stays high and Erro stays high. Recarrega clears Erro and moves the block to ESPERA_TAM.
- ResetProcessador is high in every state except LIBERA.
- Address arithmetic is 8-bit wrap-around, e.g. ENDERECO_BASE=8'hFE, N=3 writes FE, FF, 00.
- Recarrega asserted in ESPERA_TAM, CARREGA, CHECA or ATRASO has no effect.
- reset at any point, including mid-frame, aborts the frame. Memory contents already written are left as they are.

## Timing
Reset values:
- state=ESPERA_TAM, ProntoEntrada=1, EscInstr=0, EnderecoInstr=8'h00, DadoInstr=8'h00.
- ResetProcessador=1, Carregado=0, Erro=0, contador=0, soma=0.

Instruction writes:
- EscInstr, EnderecoInstr and DadoInstr are registered. They appear in the cycle after the acceptance edge and stay valid for exactly one cycle (EscInstr returns to 0 unless another byte was accepted).
- Back-to-back accepts produce back-to-back writes. The loader never stalls within a frame.

Release timing:
- The checksum is accepted at edge E. ATRASO is entered at E.
- ResetProcessador falls at edge E+CICLOS_LIBERA+1; Carregado rises on the same edge.

Error timing:
- Erro rises at the edge that accepts the bad checksum.
- ProntoEntrada drops at the same edge (ERRO state).

Recarrega timing:
- Recarrega sampled high at edge R in LIBERA or ERRO gives ESPERA_TAM from R.
- From R: ResetProcessador=1, Carregado=0, Erro=0, ProntoEntrada=1.

Total latency from the first length byte to core release, with one byte per cycle: N+2+CICLOS_LIBERA+1 edges.

## Test plan
- Good frame, ENDERECO_BASE=0, CICLOS_LIBERA=2:
  - Stream 03, 11, 22, 33, 66, one byte per cycle.
  - Required: writes 11@00, 22@01, 33@02 on consecutive cycles.
  - ResetProcessador falls 3 cycles after 66 is accepted; Carregado=1, Erro=0.
- Bad checksum:
  - Stream 02, 10, 20, 31.
  - Required: two writes occur, then Erro=1 and ProntoEntrada=0, with ResetProcessador held at 1 indefinitely.
  - Then pulse Recarrega: Erro=0 and ProntoEntrada=1.
- Gapped valid, N=0 and wrap:
  - Stream 00, 00 with ValidoEntrada toggling: no EscInstr, core released.
  - Separately, ENDERECO_BASE=FE with stream 03, 01, 02, 03, 06: writes land at FE, FF, 00.
- Reset mid-frame:
  - After 04, AA, BB, assert reset for one cycle.
  - Required: all outputs return to reset values. A new frame 01, 5A, 5A then loads 5A@00 and releases the core.
- Recarrega from LIBERA:
  - After a good load, pulse Recarrega.
  - Required: ResetProcessador=1 on the same edge. A second frame overwrites memory and releases the core again.
  - Recarrega pulses during CARREGA are ignored.

Source files
------------

// File: rtl/carregador_programa.sv
// -----------------------------------------------------------------------------
// carregador_programa
//
// Boot-time program loader placed in front of the instruction memory and the
// nRisc core. It receives a framed byte stream over a valid/ready handshake:
//
//     [ N ] [ b0 ] [ b1 ] ... [ bN-1 ] [ checksum ]
//
// Each instruction byte bk is written to instruction memory at address
// ENDERECO_BASE + k (8-bit wrap-around). The checksum byte must equal the
// modulo-256 sum of b0..bN-1. On a match, the core is released from reset
// CICLOS_LIBERA + 1 cycles after the checksum is accepted. On a mismatch, a
// sticky error is raised and the core stays in reset until Recarrega.
//
// Parameters:
//   ENDERECO_BASE     address that receives the first instruction byte
//   CICLOS_LIBERA     extra cycles of core reset after a good checksum (0..15)
//
// Ports:
//   Clock             system clock, rising edge active
//   reset             asynchronous, active-high reset
//   DadoEntrada       incoming stream byte
//   ValidoEntrada     DadoEntrada is valid this cycle
//   ProntoEntrada     loader accepts a byte this cycle
//   Recarrega         request a new load (honoured only when running or in error)
//   EscInstr          instruction-memory write enable (one cycle per byte)
//   EnderecoInstr     instruction-memory write address
//   DadoInstr         instruction-memory write data
//   ResetProcessador  active-high reset to the nRisc core
//   Carregado         core released and running
//   Erro              sticky checksum-mismatch flag
// -----------------------------------------------------------------------------
module carregador_programa #(
    parameter logic [7:0]  ENDERECO_BASE = 8'h00,
    parameter int unsigned CICLOS_LIBERA = 2
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic [7:0] DadoEntrada,
    input  logic       ValidoEntrada,
    output logic       ProntoEntrada,
    input  logic       Recarrega,
    output logic       EscInstr,
    output logic [7:0] EnderecoInstr,
    output logic [7:0] DadoInstr,
    output logic       ResetProcessador,
    output logic       Carregado,
    output logic       Erro
);

    // Release countdown fits in 4 bits because CICLOS_LIBERA is limited to 0..15.
    localparam logic [3:0] ATRASO_INICIAL = CICLOS_LIBERA[3:0];

    typedef enum logic [2:0] {
        ESPERA_TAM,  // waiting for the length byte
        CARREGA,     // receiving and writing instruction bytes
        CHECA,       // waiting for the checksum byte
        ATRASO,      // checksum good, holding core reset a few more cycles
        LIBERA,      // core released
        ERRO         // checksum mismatch, core held in reset
    } estado_t;

    estado_t    estado_q,   estado_d;
    logic [7:0] tamanho_q,  tamanho_d;   // N, number of instruction bytes
    logic [7:0] contador_q, contador_d;  // instruction bytes received so far
    logic [7:0] soma_q,     soma_d;      // running modulo-256 checksum
    logic [3:0] atraso_q,   atraso_d;    // release countdown
    logic       erro_q,     erro_d;
    logic       esc_q,      esc_d;
    logic [7:0] endereco_q, endereco_d;
    logic [7:0] dado_q,     dado_d;

    logic aceita;

    // -------------------------------------------------------------------------
    // Handshake and state-decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        ProntoEntrada    = (estado_q == ESPERA_TAM) ||
                           (estado_q == CARREGA)    ||
                           (estado_q == CHECA);
        ResetProcessador = (estado_q != LIBERA);
        // LIBERA is only reached after the countdown has expired, so being in
        // LIBERA already means the core is running.
        Carregado        = (estado_q == LIBERA);
    end

    assign aceita        = ValidoEntrada && ProntoEntrada;
    assign Erro          = erro_q;
    assign EscInstr      = esc_q;
    assign EnderecoInstr = endereco_q;
    assign DadoInstr     = dado_q;

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        estado_d   = estado_q;
        tamanho_d  = tamanho_q;
        contador_d = contador_q;
        soma_d     = soma_q;
        atraso_d   = atraso_q;
        erro_d     = erro_q;
        esc_d      = 1'b0;        // write strobe lasts exactly one cycle
        endereco_d = endereco_q;  // address/data hold between writes
        dado_d     = dado_q;

        unique case (estado_q)
            ESPERA_TAM: begin
                if (aceita) begin
                    tamanho_d  = DadoEntrada;
                    contador_d = 8'h00;
                    soma_d     = 8'h00;
                    // An empty program goes straight to the checksum byte.
                    estado_d   = (DadoEntrada == 8'h00) ? CHECA : CARREGA;
                end
            end

            CARREGA: begin
                if (aceita) begin
                    esc_d      = 1'b1;
                    endereco_d = ENDERECO_BASE + contador_q;  // 8-bit wrap
                    dado_d     = DadoEntrada;
                    soma_d     = soma_q + DadoEntrada;
                    contador_d = contador_q + 8'd1;
                    // tamanho_q is non-zero here, so tamanho_q - 1 never wraps.
                    if (contador_q == tamanho_q - 8'd1) begin
                        estado_d = CHECA;
                    end
                end
            end

            CHECA: begin
                if (aceita) begin
                    if (DadoEntrada == soma_q) begin
                        atraso_d = ATRASO_INICIAL;
                        estado_d = ATRASO;
                    end else begin
                        erro_d   = 1'b1;
                        estado_d = ERRO;
                    end
                end
            end

            ATRASO: begin
                // Leaving on the cycle the counter reads zero gives a release
                // exactly CICLOS_LIBERA + 1 edges after the checksum edge.
                if (atraso_q == 4'd0) begin
                    estado_d = LIBERA;
                end else begin
                    atraso_d = atraso_q - 4'd1;
                end
            end

            LIBERA: begin
                if (Recarrega) begin
                    estado_d = ESPERA_TAM;
                end
            end

            ERRO: begin
                if (Recarrega) begin
                    erro_d   = 1'b0;
                    estado_d = ESPERA_TAM;
                end
            end

            default: begin
                estado_d = ESPERA_TAM;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            estado_q   <= ESPERA_TAM;
            tamanho_q  <= 8'h00;
            contador_q <= 8'h00;
            soma_q     <= 8'h00;
            atraso_q   <= 4'd0;
            erro_q     <= 1'b0;
            esc_q      <= 1'b0;
            endereco_q <= 8'h00;
            dado_q     <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            estado_q   <= estado_d;
            tamanho_q  <= tamanho_d;
            contador_q <= contador_d;
            soma_q     <= soma_d;
            atraso_q   <= atraso_d;
            erro_q     <= erro_d;
            esc_q      <= esc_d;
            endereco_q <= endereco_d;
            dado_q     <= dado_d;
        end
    end

endmodule

// File: tb/tb_carregador_programa.sv
// -----------------------------------------------------------------------------
// Testbench for carregador_programa.
//
// Two instances receive the same stimulus:
//   dut0: ENDERECO_BASE=8'h00, CICLOS_LIBERA=2
//   dut1: ENDERECO_BASE=8'hFE, CICLOS_LIBERA=0 (address wrap, zero delay)
//
// The reference model works at frame level: it keeps the bytes each loader
// has accepted in the current frame and derives the expected outputs from
// them (frame complete, checksum good, release edge = checksum edge + delay
// + 1). Instruction-memory writes are captured from the DUT ports into a
// shadow memory and compared with the model's expected memory at the end.
// -----------------------------------------------------------------------------
module tb_carregador_programa;

    localparam int         NI    = 2;
    localparam logic [7:0] BASE0 = 8'h00;
    localparam logic [7:0] BASE1 = 8'hFE;
    localparam int         DLY0  = 2;
    localparam int         DLY1  = 0;

    logic       Clock = 1'b0;
    logic       reset;
    logic [7:0] DadoEntrada;
    logic       ValidoEntrada;
    logic       Recarrega;

    logic [NI-1:0] pronto_w, esc_w, rstp_w, carr_w, erro_w;
    logic [7:0]    end_w  [NI];
    logic [7:0]    dado_w [NI];

    carregador_programa #(.ENDERECO_BASE(BASE0), .CICLOS_LIBERA(DLY0)) dut0 (
        .Clock(Clock), .reset(reset),
        .DadoEntrada(DadoEntrada), .ValidoEntrada(ValidoEntrada),
        .ProntoEntrada(pronto_w[0]), .Recarrega(Recarrega),
        .EscInstr(esc_w[0]), .EnderecoInstr(end_w[0]), .DadoInstr(dado_w[0]),
        .ResetProcessador(rstp_w[0]), .Carregado(carr_w[0]), .Erro(erro_w[0])
    );

    carregador_programa #(.ENDERECO_BASE(BASE1), .CICLOS_LIBERA(DLY1)) dut1 (
        .Clock(Clock), .reset(reset),
        .DadoEntrada(DadoEntrada), .ValidoEntrada(ValidoEntrada),
        .ProntoEntrada(pronto_w[1]), .Recarrega(Recarrega),
        .EscInstr(esc_w[1]), .EnderecoInstr(end_w[1]), .DadoInstr(dado_w[1]),
        .ResetProcessador(rstp_w[1]), .Carregado(carr_w[1]), .Erro(erro_w[1])
    );

    always #5 Clock = ~Clock;

    // ------------------------------------------------------------------------
    // Bookkeeping and reference model state
    // ------------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;   // rising edges seen so far

    logic [7:0] base_m   [NI];
    int         dly_m    [NI];
    logic [7:0] fb       [NI][0:299];  // bytes accepted in the current frame
    int         fcnt     [NI];
    int         done_cyc [NI];         // edge that accepted the checksum
    logic       exp_esc  [NI];
    logic [7:0] exp_addr [NI];
    logic [7:0] exp_data [NI];
    logic [7:0] exp_mem  [NI][256];
    logic [7:0] obs_mem  [NI][256];

    logic [7:0] tx [0:299];
    int         tx_len;

    // ------------------------------------------------------------------------
    // Frame-level rules
    // ------------------------------------------------------------------------
    function automatic logic f_complete(input int i);
        return (fcnt[i] > 0) && (fcnt[i] == int'(fb[i][0]) + 2);
    endfunction

    function automatic logic f_good(input int i);
        logic [7:0] s;
        int n;
        if (!f_complete(i)) return 1'b0;
        n = int'(fb[i][0]);
        s = 8'h00;
        for (int k = 1; k <= n; k++) s = s + fb[i][k];
        return s == fb[i][n + 1];
    endfunction

    function automatic logic f_running(input int i);
        return f_good(i) && (cyc >= done_cyc[i] + dly_m[i] + 1);
    endfunction

    function automatic logic f_error(input int i);
        return f_complete(i) && !f_good(i);
    endfunction

    function automatic logic f_ready(input int i);
        return !f_complete(i);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NI; i++) begin
            fcnt[i]     = 0;
            exp_esc[i]  = 1'b0;
            exp_addr[i] = 8'h00;
            exp_data[i] = 8'h00;
        end
    endtask

    task automatic model_edge(input int i, input logic acc, input logic [7:0] d,
                              input logic hon);
        int k;
        exp_esc[i] = 1'b0;
        if (hon) begin
            fcnt[i] = 0;
        end else if (acc) begin
            k = fcnt[i];
            fb[i][k] = d;
            fcnt[i] = k + 1;
            if (k >= 1 && k <= int'(fb[i][0])) begin
                exp_esc[i]  = 1'b1;
                exp_addr[i] = 8'((int'(base_m[i]) + k - 1) % 256);
                exp_data[i] = d;
                exp_mem[i][exp_addr[i]] = d;
            end
            if (f_complete(i)) done_cyc[i] = cyc;
        end
    endtask

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    task automatic check(input string tag, input int inst,
                         input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s inst=%0d observed=%0h expected=%0h cyc=%0d",
                   tag, inst, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs(input logic full);
        for (int i = 0; i < NI; i++) begin
            check("ProntoEntrada",    i, 8'(pronto_w[i]), 8'(f_ready(i)));
            check("ResetProcessador", i, 8'(rstp_w[i]),   8'(!f_running(i)));
            check("Carregado",        i, 8'(carr_w[i]),   8'(f_running(i)));
            check("Erro",             i, 8'(erro_w[i]),   8'(f_error(i)));
            check("EscInstr",         i, 8'(esc_w[i]),    8'(exp_esc[i]));
            if (full || exp_esc[i]) begin
                check("EnderecoInstr", i, end_w[i],  exp_addr[i]);
                check("DadoInstr",     i, dado_w[i], exp_data[i]);
            end
            if (esc_w[i] === 1'b1) obs_mem[i][end_w[i]] = dado_w[i];
        end
    endtask

    // ------------------------------------------------------------------------
    // Stimulus helpers (called at the falling edge)
    // ------------------------------------------------------------------------
    task automatic ciclo(input logic v, input logic [7:0] d, input logic rc);
        logic rdy [NI];
        logic hon [NI];
        check_outputs(1'b0);
        ValidoEntrada = v;
        DadoEntrada   = d;
        Recarrega     = rc;
        for (int i = 0; i < NI; i++) begin
            rdy[i] = f_ready(i);
            hon[i] = rc && (f_running(i) || f_error(i));
        end
        @(posedge Clock);
        cyc++;
        for (int i = 0; i < NI; i++) model_edge(i, v && rdy[i], d, hon[i]);
        @(negedge Clock);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        ValidoEntrada = 1'b0;
        Recarrega     = 1'b0;
        DadoEntrada   = 8'h00;
        #1;
        model_clear();
        check_outputs(1'b1);
        @(posedge Clock);
        cyc++;
        @(negedge Clock);
        check_outputs(1'b1);
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) ciclo(1'($urandom_range(1, 0)), 8'($urandom), 1'b0);
    endtask

    task automatic recarga();
        ciclo(1'b0, 8'($urandom), 1'b1);
    endtask

    task automatic push(input logic [7:0] b);
        tx[tx_len] = b;
        tx_len++;
    endtask

    // rcmode: 0 = no Recarrega, 1 = random Recarrega, 2 = Recarrega on every byte
    task automatic send_tx(input int gap, input int rcmode);
        logic rc;
        for (int k = 0; k < tx_len; k++) begin
            repeat ($urandom_range(gap, 0)) ciclo(1'b0, 8'($urandom), 1'b0);
            rc = (rcmode == 2) ? 1'b1 :
                 (rcmode == 1) ? 1'($urandom_range(3, 0) == 0) : 1'b0;
            ciclo(1'b1, tx[k], rc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Directed and random sequence
    // ------------------------------------------------------------------------
    initial begin
        int         n;
        int         mism;
        logic [7:0] s;

        base_m[0] = BASE0;  dly_m[0] = DLY0;
        base_m[1] = BASE1;  dly_m[1] = DLY1;
        for (int i = 0; i < NI; i++) begin
            done_cyc[i] = 0;
            for (int a = 0; a < 256; a++) begin
                exp_mem[i][a] = 8'h00;
                obs_mem[i][a] = 8'h00;
            end
        end
        model_clear();
        reset         = 1'b1;
        ValidoEntrada = 1'b0;
        Recarrega     = 1'b0;
        DadoEntrada   = 8'h00;
        @(negedge Clock);
        do_reset();

        // Good frame: 03 11 22 33 66, one byte per cycle.
        tx_len = 0;
        push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h66);
        send_tx(0, 0);
        idle(6);

        // Bad checksum: 02 10 20 31 (sum is 30); error must persist.
        recarga();
        tx_len = 0;
        push(8'h02); push(8'h10); push(8'h20); push(8'h31);
        send_tx(0, 0);
        idle(12);
        recarga();

        // Empty program with ValidoEntrada toggling.
        ciclo(1'b0, 8'hFF, 1'b0);
        ciclo(1'b1, 8'h00, 1'b0);
        ciclo(1'b0, 8'h77, 1'b0);
        ciclo(1'b1, 8'h00, 1'b0);
        idle(5);

        // Wrap: 03 01 02 03 06 (dut1 writes FE, FF, 00).
        recarga();
        tx_len = 0;
        push(8'h03); push(8'h01); push(8'h02); push(8'h03); push(8'h06);
        send_tx(0, 0);
        idle(5);

        // Reset mid-frame, then a fresh one-byte frame.
        recarga();
        tx_len = 0;
        push(8'h04); push(8'hAA); push(8'hBB);
        send_tx(0, 0);
        do_reset();
        tx_len = 0;
        push(8'h01); push(8'h5A); push(8'h5A);
        send_tx(0, 0);
        idle(5);

        // Reload from LIBERA with Recarrega held during the whole frame.
        recarga();
        tx_len = 0;
        push(8'h04); push(8'hC1); push(8'h02); push(8'h13); push(8'h44);
        push(8'(8'hC1 + 8'h02 + 8'h13 + 8'h44));
        send_tx(0, 2);
        idle(5);

        // Random frames with random gaps and stray Recarrega pulses.
        for (int r = 0; r < 10; r++) begin
            recarga();
            n = (r == 9) ? 40 : $urandom_range(8, 0);
            tx_len = 0;
            s = 8'h00;
            push(8'(n));
            for (int k = 0; k < n; k++) begin
                push(8'($urandom));
                s = s + tx[tx_len - 1];
            end
            if ($urandom_range(3, 0) == 0) push(s + 8'($urandom_range(255, 1)));
            else push(s);
            send_tx(2, 1);
            idle(5);
        end

        // Compare captured instruction memory with the expected image.
        for (int i = 0; i < NI; i++) begin
            mism = 0;
            for (int a = 0; a < 256; a++) begin
                if (obs_mem[i][a] !== exp_mem[i][a]) mism++;
            end
            check("mem_mismatches", i, 8'((mism > 255) ? 255 : mism), 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
